// File: rtl/cnna_sched_pkg.sv
// Shared types and defaults for the cnna loop-nest scheduler.
package cnna_sched_pkg;

  localparam int unsigned CNNA_C_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sched_wrap_cnt.sv
// One loop level: wrapping index counter with last-index flags for the carry chain.
module sched_wrap_cnt
  import cnna_sched_pkg::*;
#(
  parameter int unsigned C_WIDTH = CNNA_C_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_inc,
  input  logic [C_WIDTH-1:0] i_bound,
  output logic [C_WIDTH-1:0] o_index,
  output logic               o_at_last_c,
  output logic               o_at_last_nxt_c
);

  logic [C_WIDTH-1:0] r_index;
  logic [C_WIDTH-1:0] w_bound_m1;
  logic [C_WIDTH-1:0] w_bound_m2;

  assign w_bound_m1 = i_bound - C_WIDTH'(1);
  assign w_bound_m2 = i_bound - C_WIDTH'(2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_index <= '0;
    end else if (i_clr) begin
      r_index <= '0;
    end else if (i_inc) begin
      r_index <= o_at_last_c ? '0 : r_index + C_WIDTH'(1);
    end
  end

  assign o_index     = r_index;
  assign o_at_last_c = (r_index == w_bound_m1);

  // Predicts whether the index will sit on its last value after this cycle.
  assign o_at_last_nxt_c = !i_inc      ? o_at_last_c :
                           o_at_last_c ? (i_bound == C_WIDTH'(1)) :
                                         (r_index == w_bound_m2);

endmodule

// File: rtl/cnna_loop_sched.sv
// Three-level (ch/row/col) loop-nest scheduler issuing index beats over valid/ready.
module cnna_loop_sched
  import cnna_sched_pkg::*;
#(
  parameter int unsigned C_WIDTH = CNNA_C_WIDTH
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_start,
  input  logic               I_clr,
  input  logic [C_WIDTH-1:0] I_col_upper,
  input  logic [C_WIDTH-1:0] I_row_upper,
  input  logic [C_WIDTH-1:0] I_ch_upper,
  input  logic               I_ready,
  output logic               O_busy,
  output logic               O_valid,
  output logic [C_WIDTH-1:0] O_col,
  output logic [C_WIDTH-1:0] O_row,
  output logic [C_WIDTH-1:0] O_ch,
  output logic               O_first,
  output logic               O_last,
  output logic               O_done,
  output logic               O_cfg_err
);

  sched_state_e       r_state;
  logic [C_WIDTH-1:0] r_col_bound;
  logic [C_WIDTH-1:0] r_row_bound;
  logic [C_WIDTH-1:0] r_ch_bound;
  logic               r_valid;
  logic               r_busy;
  logic               r_first;
  logic               r_last;
  logic               r_done;
  logic               r_cfg_err;

  logic w_xfer;
  logic w_row_inc;
  logic w_ch_inc;
  logic w_col_last;
  logic w_row_last;
  logic w_ch_last;
  logic w_col_last_nxt;
  logic w_row_last_nxt;
  logic w_ch_last_nxt;
  logic w_tile_end;
  logic w_bad_cfg;
  logic w_unit_cfg;

  // Carry chain: an outer level steps only when every inner level wraps.
  assign w_xfer     = r_valid & I_ready;
  assign w_row_inc  = w_xfer & w_col_last;
  assign w_ch_inc   = w_row_inc & w_row_last;
  assign w_tile_end = w_ch_inc & w_ch_last;

  assign w_bad_cfg  = (I_col_upper == '0) | (I_row_upper == '0) | (I_ch_upper == '0);
  assign w_unit_cfg = (I_col_upper == C_WIDTH'(1)) & (I_row_upper == C_WIDTH'(1)) &
                      (I_ch_upper == C_WIDTH'(1));

  sched_wrap_cnt #(.C_WIDTH(C_WIDTH)) u_col_cnt (
    .i_clk           (I_clk),
    .i_rst_n         (I_rst_n),
    .i_clr           (I_clr),
    .i_inc           (w_xfer),
    .i_bound         (r_col_bound),
    .o_index         (O_col),
    .o_at_last_c     (w_col_last),
    .o_at_last_nxt_c (w_col_last_nxt)
  );

  sched_wrap_cnt #(.C_WIDTH(C_WIDTH)) u_row_cnt (
    .i_clk           (I_clk),
    .i_rst_n         (I_rst_n),
    .i_clr           (I_clr),
    .i_inc           (w_row_inc),
    .i_bound         (r_row_bound),
    .o_index         (O_row),
    .o_at_last_c     (w_row_last),
    .o_at_last_nxt_c (w_row_last_nxt)
  );

  sched_wrap_cnt #(.C_WIDTH(C_WIDTH)) u_ch_cnt (
    .i_clk           (I_clk),
    .i_rst_n         (I_rst_n),
    .i_clr           (I_clr),
    .i_inc           (w_ch_inc),
    .i_bound         (r_ch_bound),
    .o_index         (O_ch),
    .o_at_last_c     (w_ch_last),
    .o_at_last_nxt_c (w_ch_last_nxt)
  );

  // Control FSM with registered flags; clr overrides everything but reset.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state     <= ST_IDLE;
      r_col_bound <= '0;
      r_row_bound <= '0;
      r_ch_bound  <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (I_clr) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_first <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (I_start) begin
              r_col_bound <= I_col_upper;
              r_row_bound <= I_row_upper;
              r_ch_bound  <= I_ch_upper;
              if (w_bad_cfg) begin
                r_cfg_err <= 1'b1;
              end else begin
                r_state <= ST_RUN;
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
                r_first <= 1'b1;
                r_last  <= w_unit_cfg;
              end
            end
          end
          ST_RUN: begin
            if (w_tile_end) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_first <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_xfer) begin
              r_first <= 1'b0;
              r_last  <= w_col_last_nxt & w_row_last_nxt & w_ch_last_nxt;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign O_busy    = r_busy;
  assign O_valid   = r_valid;
  assign O_first   = r_first;
  assign O_last    = r_last;
  assign O_done    = r_done;
  assign O_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_cnna_loop_sched.sv
// Directed self-checking bench for cnna_loop_sched.
module tb_cnna_loop_sched;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         clr;
  logic [W-1:0] col_upper;
  logic [W-1:0] row_upper;
  logic [W-1:0] ch_upper;
  logic         ready;
  logic         busy;
  logic         valid;
  logic [W-1:0] col;
  logic [W-1:0] row;
  logic [W-1:0] ch;
  logic         first;
  logic         last;
  logic         done;
  logic         cfg_err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  cnna_loop_sched #(.C_WIDTH(W)) dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_start     (start),
    .I_clr       (clr),
    .I_col_upper (col_upper),
    .I_row_upper (row_upper),
    .I_ch_upper  (ch_upper),
    .I_ready     (ready),
    .O_busy      (busy),
    .O_valid     (valid),
    .O_col       (col),
    .O_row       (row),
    .O_ch        (ch),
    .O_first     (first),
    .O_last      (last),
    .O_done      (done),
    .O_cfg_err   (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_idx"},   32'({ch, row, col}), 32'd0);
    check({tag, "_fl"},    32'({first, last}),  32'd0);
  endtask

  task automatic start_tile(input int c, input int r, input int h);
    col_upper = W'(c);
    row_upper = W'(r);
    ch_upper  = W'(h);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0; 2: ready high plus mid-run start/bound poke
  task automatic run_beats(input int c, input int r, input int h, input int mode);
    int   ec    = 0;
    int   er    = 0;
    int   eh    = 0;
    int   xfers = 0;
    int   cyc   = 0;
    int   total = c * r * h;
    logic rdy;
    while (xfers < total && cyc < total * 4 + 8) begin
      rdy = (mode == 1) ? ((cyc % 3) == 0) : 1'b1;
      if (mode == 2 && cyc == 2) begin
        start     = 1'b1;
        col_upper = W'(5);
        row_upper = W'(5);
        ch_upper  = W'(5);
      end else if (mode == 2 && cyc == 3) begin
        start = 1'b0;
      end
      ready = rdy;
      check("beat_valid", 32'(valid), 32'd1);
      check("beat_busy",  32'(busy),  32'd1);
      check("beat_col",   32'(col),   32'(ec));
      check("beat_row",   32'(row),   32'(er));
      check("beat_ch",    32'(ch),    32'(eh));
      check("beat_first", 32'(first), 32'(ec == 0 && er == 0 && eh == 0));
      check("beat_last",  32'(last),  32'(ec == c - 1 && er == r - 1 && eh == h - 1));
      check("beat_done",  32'(done),  32'd0);
      step();
      cyc++;
      if (rdy) begin
        xfers++;
        if (ec == c - 1) begin
          ec = 0;
          if (er == r - 1) begin
            er = 0;
            eh = eh + 1;
          end else begin
            er = er + 1;
          end
        end else begin
          ec = ec + 1;
        end
      end
    end
    start = 1'b0;
    check("xfer_count", 32'(xfers), 32'(total));
    check("done_valid", 32'(valid), 32'd0);
    check("done_pulse", 32'(done),  32'd1);
    check("done_busy",  32'(busy),  32'd1);
    step();
    check_idle("post_done");
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    clr       = 1'b0;
    ready     = 1'b0;
    col_upper = '0;
    row_upper = '0;
    ch_upper  = '0;
    step();
    check_idle("reset");
    check("reset_err", 32'(cfg_err), 32'd0);
    #2 rst_n = 1'b1;
    step();

    // 2/2/2 full throughput
    start_tile(2, 2, 2);
    run_beats(2, 2, 2, 0);

    // 3/1/2 with backpressure
    start_tile(3, 1, 2);
    run_beats(3, 1, 2, 1);

    // single-beat tile
    start_tile(1, 1, 1);
    run_beats(1, 1, 1, 0);

    // zero bound rejected
    start_tile(0, 2, 2);
    check("cfg_err_pulse", 32'(cfg_err), 32'd1);
    check("cfg_err_valid", 32'(valid),   32'd0);
    check("cfg_err_busy",  32'(busy),    32'd0);
    step();
    check("cfg_err_clear", 32'(cfg_err), 32'd0);
    check_idle("cfg_err_after");

    // start and bound changes during RUN ignored
    start_tile(2, 2, 2);
    run_beats(2, 2, 2, 2);

    // maximum-range column bound
    start_tile(255, 1, 1);
    run_beats(255, 1, 1, 0);

    // clr and start together: clr wins
    col_upper = W'(2);
    row_upper = W'(2);
    ch_upper  = W'(2);
    clr       = 1'b1;
    start     = 1'b1;
    step();
    clr       = 1'b0;
    start     = 1'b0;
    check_idle("clr_start");
    step();
    check_idle("clr_start_next");

    // clr at beat 3 of 2/2/2, then restart
    start_tile(2, 2, 2);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("clr_pre_col", 32'(col), 32'(i % 2));
      check("clr_pre_row", 32'(row), 32'(i / 2));
      step();
    end
    check("clr_beat3_col", 32'(col), 32'd1);
    check("clr_beat3_row", 32'(row), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_idle("clr_after");
    step();
    check_idle("clr_no_done");
    start_tile(2, 2, 2);
    run_beats(2, 2, 2, 0);

    // async reset mid-RUN
    start_tile(2, 2, 2);
    ready = 1'b1;
    step();
    step();
    check("arst_pre_valid", 32'(valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("arst");
    #2 rst_n = 1'b1;
    step();
    check_idle("arst_release");
    start_tile(2, 1, 1);
    run_beats(2, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
